toggle_code_decoder: RTL and testbench

- Receive-side partner of the two-state key toggle encoder.
- The encoder emits a 2-bit code per cycle: 2'b00 idle, 2'b01 for a press in the red phase (red to green), 2'b10 for a press in the green phase (green to red). 2'b11 is never legal.
- This block tracks the encoder's phase and reconstructs the key presses.
- It counts presses, detects phase/illegal-code faults, and re-locks automatically after a fault.

---
 rtl/toggle_code_decoder_if.sv | 25 ++
 rtl/toggle_code_decoder.sv | 109 ++++++++++
 tb/tb_toggle_code_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/toggle_code_decoder_if.sv
// Bus between the toggle-code encoder side and the decoder: the code/clear inputs
// and the decoded press/fault status.
interface toggle_code_decoder_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
);
  logic [1:0]       code;
  logic             clear;
  logic             key_event;
  logic             phase;
  logic             locked;
  logic             fault;
  logic [CNT_W-1:0] press_count;
  logic [ERR_W-1:0] fault_count;

  modport master (
    output code, clear,
    input  key_event, phase, locked, fault, press_count, fault_count
  );

  modport slave (
    input  code, clear,
    output key_event, phase, locked, fault, press_count, fault_count
  );
endinterface

// File: rtl/toggle_code_decoder.sv
// Receive-side decoder for the two-state key toggle encoder: tracks the encoder
// phase, reconstructs presses, counts faults and re-locks on the next press code.
module toggle_code_decoder #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  toggle_code_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EXPECT_01 = 2'd0,
    S_EXPECT_10 = 2'd1,
    S_FAULT     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             phase_q, phase_d;
  logic             locked_q, locked_d;
  logic             key_event_q, key_event_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic [ERR_W-1:0] fault_count_q, fault_count_d;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             accept;
  logic             fault_hit;
  logic [CNT_W-1:0] press_base;
  logic [ERR_W-1:0] fault_cnt_base;

  always_comb begin
    accept    = 1'b0;
    fault_hit = 1'b0;
    case (state_q)
      S_EXPECT_01: begin
        accept    = (bus.code == 2'b01);
        fault_hit = bus.code[1];
      end
      S_EXPECT_10: begin
        accept    = (bus.code == 2'b10);
        fault_hit = bus.code[0];
      end
      default: begin
        // In FAULT either press code re-locks; only 11 keeps counting faults.
        accept    = (bus.code == 2'b01) || (bus.code == 2'b10);
        fault_hit = (bus.code == 2'b11);
      end
    endcase
  end

  // Clear zeroes the counters before the current code's effect is layered on top.
  always_comb begin
    press_base     = bus.clear ? '0 : press_count_q;
    fault_cnt_base = bus.clear ? '0 : fault_count_q;

    state_d       = state_q;
    phase_d       = phase_q;
    locked_d      = locked_q;
    key_event_d   = 1'b0;
    fault_d       = bus.clear ? 1'b0 : fault_q;
    press_count_d = press_base;
    fault_count_d = fault_cnt_base;

    if (accept) begin
      phase_d       = (bus.code == 2'b01);
      state_d       = (bus.code == 2'b01) ? S_EXPECT_10 : S_EXPECT_01;
      locked_d      = 1'b1;
      key_event_d   = 1'b1;
      press_count_d = press_base + 1'b1;
    end else if (fault_hit) begin
      state_d       = S_FAULT;
      locked_d      = 1'b0;
      fault_d       = 1'b1;
      fault_count_d = sat_inc(fault_cnt_base);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_EXPECT_01;
      phase_q       <= 1'b0;
      locked_q      <= 1'b1;
      key_event_q   <= 1'b0;
      fault_q       <= 1'b0;
      press_count_q <= '0;
      fault_count_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      locked_q      <= locked_d;
      key_event_q   <= key_event_d;
      fault_q       <= fault_d;
      press_count_q <= press_count_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign bus.key_event   = key_event_q;
  assign bus.phase       = phase_q;
  assign bus.locked      = locked_q;
  assign bus.fault       = fault_q;
  assign bus.press_count = press_count_q;
  assign bus.fault_count = fault_count_q;

endmodule

// File: tb/tb_toggle_code_decoder.sv
// Bench for toggle_code_decoder: directed scenarios plus random traffic, checked
// against a rule-level model of the encoder phase and the two counters.
module tb_toggle_code_decoder;
  localparam int CNT_W = 8;
  localparam int ERR_W = 4;
  localparam int PMOD  = 1 << CNT_W;
  localparam int FMAX  = (1 << ERR_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  toggle_code_decoder_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  toggle_code_decoder #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;

  // Reference model: "locked" means the next press code must match the phase
  // (red expects 01, green expects 10); unlocked means any press code re-locks.
  int m_press, m_fcnt;
  bit m_phase, m_locked, m_fault, m_kev;

  task automatic model_fault();
    m_fault  = 1'b1;
    m_locked = 1'b0;
    if (m_fcnt < FMAX) m_fcnt++;
  endtask

  task automatic model_step(input logic [1:0] c, input logic clr, input logic rst);
    if (rst) begin
      m_press = 0; m_fcnt = 0; m_phase = 0; m_locked = 1; m_fault = 0; m_kev = 0;
      return;
    end
    m_kev = 0;
    if (clr) begin
      m_press = 0; m_fcnt = 0; m_fault = 0;
    end
    if (c == 2'b11) model_fault();
    else if (c != 2'b00) begin
      if (!m_locked || c == (m_phase ? 2'b10 : 2'b01)) begin
        m_phase  = (c == 2'b01);
        m_locked = 1'b1;
        m_kev    = 1'b1;
        m_press  = (m_press + 1) % PMOD;
      end else model_fault();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("key_event",   32'(bus.key_event),   32'(m_kev));
    chk("phase",       32'(bus.phase),       32'(m_phase));
    chk("locked",      32'(bus.locked),      32'(m_locked));
    chk("fault",       32'(bus.fault),       32'(m_fault));
    chk("press_count", 32'(bus.press_count), 32'(m_press));
    chk("fault_count", 32'(bus.fault_count), 32'(m_fcnt));
  endtask

  // Drive one sample, let it be clocked in, then compare outputs 1 ns later.
  task automatic step(input logic [1:0] c, input logic clr, input logic rst);
    bus.code  = c;
    bus.clear = clr;
    reset     = rst;
    @(posedge clock);
    model_step(c, clr, rst);
    #1;
    check_all();
  endtask

  int kev_run;

  initial begin
    bus.code  = 2'b00;
    bus.clear = 1'b0;
    step(2'b00, 1'b0, 1'b1);
    step(2'b01, 1'b0, 1'b1);
    chk("reset_locked", 32'(bus.locked), 32'd1);
    chk("reset_press",  32'(bus.press_count), 32'd0);

    // Basic press sequence with idles.
    step(2'b01, 0, 0); chk("seq_phase0", 32'(bus.phase), 32'd1);
    step(2'b00, 0, 0); chk("seq_phase1", 32'(bus.phase), 32'd1);
    step(2'b10, 0, 0); chk("seq_phase2", 32'(bus.phase), 32'd0);
    step(2'b00, 0, 0);
    step(2'b01, 0, 0);
    chk("seq_press", 32'(bus.press_count), 32'd3);
    chk("seq_fault", 32'(bus.fault), 32'd0);

    // Phase error straight after reset, then re-lock.
    step(2'b00, 0, 1);
    step(2'b10, 0, 0);
    chk("perr_fault",  32'(bus.fault),       32'd1);
    chk("perr_fcnt",   32'(bus.fault_count), 32'd1);
    chk("perr_locked", 32'(bus.locked),      32'd0);
    step(2'b01, 0, 0);
    chk("relock_locked", 32'(bus.locked), 32'd1);
    chk("relock_press",  32'(bus.press_count), 32'd1);
    chk("relock_fault",  32'(bus.fault), 32'd1);

    // Held key: back-to-back alternating codes.
    step(2'b00, 0, 1);
    kev_run = 0;
    for (int i = 0; i < 4; i++) begin
      step((i % 2 == 0) ? 2'b01 : 2'b10, 0, 0);
      if (bus.key_event === 1'b1) kev_run++;
    end
    chk("held_kev_run", 32'(kev_run), 32'd4);
    chk("held_press",   32'(bus.press_count), 32'd4);
    chk("held_phase",   32'(bus.phase), 32'd0);

    // Illegal flood saturates the fault counter.
    for (int i = 0; i < 20; i++) step(2'b11, 0, 0);
    chk("flood_fcnt",  32'(bus.fault_count), 32'd15);
    chk("flood_press", 32'(bus.press_count), 32'd4);

    // Press counter wrap, then clear alongside a valid press.
    step(2'b00, 0, 1);
    for (int i = 0; i < 256; i++) step((i % 2 == 0) ? 2'b01 : 2'b10, 0, 0);
    chk("wrap_press", 32'(bus.press_count), 32'd0);
    step(2'b01, 1, 0);
    chk("clr_press", 32'(bus.press_count), 32'd1);
    chk("clr_fault", 32'(bus.fault), 32'd0);
    step(2'b11, 1, 0);
    chk("clr_fault_code", 32'(bus.fault_count), 32'd1);

    // Reset mid-stream in EXPECT_10 with a sticky fault.
    step(2'b00, 0, 1);
    step(2'b01, 0, 0); step(2'b11, 0, 0); step(2'b10, 0, 0);
    step(2'b01, 0, 0); step(2'b10, 0, 0); step(2'b01, 0, 0);
    chk("mid_press", 32'(bus.press_count), 32'd5);
    step(2'b10, 0, 1);
    chk("mid_rst_press", 32'(bus.press_count), 32'd0);
    chk("mid_rst_phase", 32'(bus.phase), 32'd0);

    // Random traffic, biased toward the expected next code.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] c;
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      c = m_phase ? 2'b10 : 2'b01;
      else if (r < 65) c = 2'b00;
      else             c = 2'($urandom_range(0, 3));
      step(c, ($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
